// File: rtl/gbp_upd_sched.sv
// gbp_upd_sched: update scheduler for a gshare-style branch predictor.
// After reset or flush it walks every predictor row, writing the reset
// counter value. It then queues resolved-branch updates into a small FIFO
// and issues them as single-column writes, maintaining the global history
// register.
// Optional feature: define GBP_SCHED_BYPASS_EN to let a request reach cmd_*
// in the same cycle when the queue is empty.
module gbp_upd_sched #(
  parameter int unsigned NR_ROWS = 512,
  parameter int unsigned COLS    = 2,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned IDX_W  = $clog2(NR_ROWS),
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             debug_mode_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [IDX_W-1:0] req_index_i,
  input  logic [COL_W-1:0] req_col_i,
  input  logic             req_taken_i,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic [IDX_W-1:0] cmd_index_o,
  output logic [COLS-1:0]  cmd_col_mask_o,
  output logic             cmd_init_o,
  output logic             cmd_taken_o,
  output logic [IDX_W-1:0] ghr_o,
  output logic             busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_FLUSH, S_RUN} state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [COL_W-1:0] col;
    logic             taken;
  } ent_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] ghr_q;
  ent_t             mem_q [DEPTH];

  logic run, empty, full, req_fire, req_live, byp, push, pop, clear;
  ent_t head, req_ent;

  assign run      = (state_q == S_RUN);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign req_ent  = '{idx: req_index_i, col: req_col_i, taken: req_taken_i};

  // Readiness depends only on queue occupancy and flush, never on cmd_ready_i.
  assign req_ready_o = run && !full && !flush_i;
  assign req_fire    = req_valid_i && req_ready_o;
  // Requests taken while in debug mode are consumed but have no effect.
  assign req_live    = req_fire && !debug_mode_i;

`ifdef GBP_SCHED_BYPASS_EN
  assign byp = run && empty && req_live;
`else
  assign byp = 1'b0;
`endif

  assign pop   = run && !empty && cmd_ready_i;
  // A bypassed request that the RAM takes immediately never enters the queue.
  assign push  = req_live && !(byp && cmd_ready_i);
  assign clear = run && flush_i;

  assign busy_o = (state_q == S_FLUSH);
  assign ghr_o  = ghr_q;

  // Command mux: init walk, queue head, or (optionally) the live request.
  always_comb begin
    cmd_valid_o    = 1'b0;
    cmd_index_o    = '0;
    cmd_col_mask_o = '0;
    cmd_init_o     = 1'b0;
    cmd_taken_o    = 1'b0;
    if (!run) begin
      cmd_valid_o    = 1'b1;
      cmd_init_o     = 1'b1;
      cmd_index_o    = row_q;
      cmd_col_mask_o = '1;
    end else if (!empty) begin
      cmd_valid_o    = 1'b1;
      cmd_index_o    = head.idx;
      cmd_col_mask_o = COLS'(1) << head.col;
      cmd_taken_o    = head.taken;
    end else if (byp) begin
      cmd_valid_o    = 1'b1;
      cmd_index_o    = req_ent.idx;
      cmd_col_mask_o = COLS'(1) << req_ent.col;
      cmd_taken_o    = req_ent.taken;
    end
  end

  // Next-state: row walk advances on each accepted beat; flush restarts it.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      S_FLUSH: begin
        if (flush_i) begin
          row_d = '0;
        end else if (cmd_ready_i) begin
          if (row_q == IDX_W'(NR_ROWS - 1)) begin
            state_d = S_RUN;
            row_d   = '0;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_FLUSH;
          row_d   = '0;
        end
      end
      default: begin
        state_d = S_FLUSH;
        row_d   = '0;
      end
    endcase
  end

  // State and row counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FLUSH;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Queue pointers, occupancy and history; flush discards everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ghr_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ghr_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (req_live) ghr_q <= {ghr_q[IDX_W-2:0], req_taken_i};
    end
  end

  // Queue storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= req_ent;
  end

endmodule

// File: tb/tb_gbp_upd_sched.sv
// Directed bench for gbp_upd_sched with NR_ROWS=8, COLS=2, DEPTH=4.
module tb_gbp_upd_sched;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic       debug_mode_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [2:0] req_index_i = '0;
  logic       req_col_i = 1'b0;
  logic       req_taken_i = 1'b0;
  logic       cmd_valid_o;
  logic       cmd_ready_i = 1'b0;
  logic [2:0] cmd_index_o;
  logic [1:0] cmd_col_mask_o;
  logic       cmd_init_o;
  logic       cmd_taken_o;
  logic [2:0] ghr_o;
  logic       busy_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] ghr_exp = '0;

  gbp_upd_sched #(.NR_ROWS(8), .COLS(2), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_index_i(req_index_i),
    .req_col_i(req_col_i), .req_taken_i(req_taken_i), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .cmd_index_o(cmd_index_o), .cmd_col_mask_o(cmd_col_mask_o),
    .cmd_init_o(cmd_init_o), .cmd_taken_o(cmd_taken_o), .ghr_o(ghr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; #1;
    n_cmp++;
    if ({busy_o, req_ready_o, ghr_o} !== {1'b1, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL reset_state busy=%b rdy=%b ghr=%0d want 1 0 0", busy_o, req_ready_o, ghr_o);
    end
    step;
    n_cmp++;
    if ({busy_o, req_ready_o, ghr_o, cmd_index_o} !== {1'b1, 1'b0, 3'd0, 3'd0}) begin
      n_err++; $display("FAIL reset_hold busy=%b rdy=%b ghr=%0d idx=%0d want 1 0 0 0", busy_o, req_ready_o, ghr_o, cmd_index_o);
    end
  endtask

  task automatic test_flush_walk;
    cmd_ready_i = 1'b1;
    rst_ni = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({cmd_valid_o, cmd_init_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o, busy_o, req_ready_o}
          !== {1'b1, 1'b1, 3'(i), 2'b11, 1'b0, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL walk_beat%0d v=%b init=%b idx=%0d mask=%b busy=%b rdy=%b want idx=%0d init walk",
                          i, cmd_valid_o, cmd_init_o, cmd_index_o, cmd_col_mask_o, busy_o, req_ready_o, i);
      end
      step;
    end
    n_cmp++;
    if ({busy_o, req_ready_o, cmd_valid_o} !== 3'b010) begin
      n_err++; $display("FAIL walk_done busy=%b rdy=%b v=%b want 0 1 0", busy_o, req_ready_o, cmd_valid_o);
    end
    ghr_exp = '0;
  endtask

  task automatic test_single;
    req_valid_i = 1'b1; req_index_i = 3'd3; req_col_i = 1'b1; req_taken_i = 1'b1; cmd_ready_i = 1'b1; #1;
`ifdef GBP_SCHED_BYPASS_EN
    n_cmp++;
    if ({cmd_valid_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o, cmd_init_o} !== {1'b1, 3'd3, 2'b10, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL single_bypass v=%b idx=%0d mask=%b tk=%b init=%b want 1 3 10 1 0",
                        cmd_valid_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o, cmd_init_o);
    end
    step; req_valid_i = 1'b0; #1;
`else
    n_cmp++;
    if ({cmd_valid_o, req_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL single_lat0 v=%b rdy=%b want 0 1", cmd_valid_o, req_ready_o);
    end
    step; req_valid_i = 1'b0; #1;
    n_cmp++;
    if ({cmd_valid_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o, cmd_init_o} !== {1'b1, 3'd3, 2'b10, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL single_lat1 v=%b idx=%0d mask=%b tk=%b init=%b want 1 3 10 1 0",
                        cmd_valid_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o, cmd_init_o);
    end
    step;
`endif
    ghr_exp = {ghr_exp[1:0], 1'b1};
    n_cmp++;
    if ({cmd_valid_o, ghr_o} !== {1'b0, 3'd1}) begin
      n_err++; $display("FAIL single_after v=%b ghr=%0d want 0 1", cmd_valid_o, ghr_o);
    end
  endtask

  task automatic test_fill;
    logic [2:0] fi [5] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic       fc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       ft [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] m;
    cmd_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_valid_i = 1'b1; req_index_i = fi[k]; req_col_i = fc[k]; req_taken_i = ft[k]; #1;
      n_cmp++;
      if (req_ready_o !== (k < 4)) begin
        n_err++; $display("FAIL fill_ready%0d rdy=%b want %b", k, req_ready_o, (k < 4));
      end
      if (k < 4) ghr_exp = {ghr_exp[1:0], ft[k]};
      step;
    end
    req_valid_i = 1'b0; #1;
    n_cmp++;
    if (ghr_o !== ghr_exp) begin
      n_err++; $display("FAIL fill_ghr ghr=%b want %b", ghr_o, ghr_exp);
    end
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({cmd_valid_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o} !== {1'b1, 3'd1, 2'b01, 1'b1}) begin
        n_err++; $display("FAIL fill_stall%0d v=%b idx=%0d mask=%b tk=%b want 1 1 01 1",
                          s, cmd_valid_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o);
      end
      step;
    end
    cmd_ready_i = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      m = fc[k] ? 2'b10 : 2'b01;
      n_cmp++;
      if ({cmd_valid_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o} !== {1'b1, fi[k], m, ft[k]}) begin
        n_err++; $display("FAIL drain%0d v=%b idx=%0d mask=%b tk=%b want 1 %0d %b %b",
                          k, cmd_valid_o, cmd_index_o, cmd_col_mask_o, cmd_taken_o, fi[k], m, ft[k]);
      end
      step;
    end
    n_cmp++;
    if ({cmd_valid_o, req_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL drain_empty v=%b rdy=%b want 0 1", cmd_valid_o, req_ready_o);
    end
  endtask

  task automatic test_debug;
    debug_mode_i = 1'b1; cmd_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid_i = 1'b1; req_index_i = 3'(k); req_col_i = 1'(k); req_taken_i = 1'b1; #1;
      n_cmp++;
      if ({req_ready_o, cmd_valid_o} !== 2'b10) begin
        n_err++; $display("FAIL debug_req%0d rdy=%b v=%b want 1 0", k, req_ready_o, cmd_valid_o);
      end
      step;
    end
    req_valid_i = 1'b0; debug_mode_i = 1'b0; #1;
    n_cmp++;
    if ({cmd_valid_o, ghr_o} !== {1'b0, ghr_exp}) begin
      n_err++; $display("FAIL debug_after v=%b ghr=%b want 0 %b", cmd_valid_o, ghr_o, ghr_exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] bi [3] = '{3'd6, 3'd2, 3'd5};
    logic       bt [3] = '{1'b0, 1'b1, 1'b1};
    logic       ev;
    logic [2:0] ei;
    cmd_ready_i = 1'b1; req_col_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid_i = (k < 3);
      if (k < 3) begin req_index_i = bi[k]; req_taken_i = bt[k]; ghr_exp = {ghr_exp[1:0], bt[k]}; end
      #1;
`ifdef GBP_SCHED_BYPASS_EN
      ev = (k < 3); ei = (k < 3) ? bi[k] : 3'd0;
`else
      ev = (k > 0); ei = (k > 0) ? bi[k-1] : 3'd0;
`endif
      n_cmp++;
      if (cmd_valid_o !== ev || (ev && cmd_index_o !== ei)) begin
        n_err++; $display("FAIL b2b%0d v=%b idx=%0d want %b %0d", k, cmd_valid_o, cmd_index_o, ev, ei);
      end
      step;
    end
    req_valid_i = 1'b0; #1;
    n_cmp++;
    if ({cmd_valid_o, ghr_o} !== {1'b0, ghr_exp}) begin
      n_err++; $display("FAIL b2b_after v=%b ghr=%b want 0 %b", cmd_valid_o, ghr_o, ghr_exp);
    end
  endtask

  task automatic test_flush;
    cmd_ready_i = 1'b0; req_valid_i = 1'b1;
    req_index_i = 3'd7; req_col_i = 1'b0; req_taken_i = 1'b1; step;
    req_index_i = 3'd0; req_col_i = 1'b1; req_taken_i = 1'b1; step;
    req_valid_i = 1'b0; #1;
    n_cmp++;
    if (cmd_valid_o !== 1'b1) begin
      n_err++; $display("FAIL flush_queued v=%b want 1", cmd_valid_o);
    end
    flush_i = 1'b1; req_valid_i = 1'b1; req_index_i = 3'd2; #1;
    n_cmp++;
    if (req_ready_o !== 1'b0) begin
      n_err++; $display("FAIL flush_block rdy=%b want 0", req_ready_o);
    end
    step;
    flush_i = 1'b0; req_valid_i = 1'b0; ghr_exp = '0; #1;
    n_cmp++;
    if ({busy_o, ghr_o, cmd_init_o, cmd_index_o} !== {1'b1, 3'd0, 1'b1, 3'd0}) begin
      n_err++; $display("FAIL flush_enter busy=%b ghr=%0d init=%b idx=%0d want 1 0 1 0", busy_o, ghr_o, cmd_init_o, cmd_index_o);
    end
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step;
    n_cmp++;
    if (cmd_index_o !== 3'd5) begin
      n_err++; $display("FAIL flush_row5 idx=%0d want 5", cmd_index_o);
    end
    flush_i = 1'b1; #1;
    step;
    flush_i = 1'b0; #1;
    n_cmp++;
    if ({busy_o, cmd_index_o} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL flush_restart busy=%b idx=%0d want 1 0", busy_o, cmd_index_o);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({cmd_init_o, cmd_index_o} !== {1'b1, 3'(i)}) begin
        n_err++; $display("FAIL rewalk%0d init=%b idx=%0d want 1 %0d", i, cmd_init_o, cmd_index_o, i);
      end
      step;
    end
    n_cmp++;
    if ({busy_o, cmd_valid_o, ghr_o} !== {1'b0, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL flush_done busy=%b v=%b ghr=%0d want 0 0 0", busy_o, cmd_valid_o, ghr_o);
    end
  endtask

  task automatic test_stall_walk;
    int exp_row;
    int cyc;
    cmd_ready_i = 1'b0; req_valid_i = 1'b1; req_index_i = 3'd4; req_col_i = 1'b0; req_taken_i = 1'b1;
    step;
    req_valid_i = 1'b0;
    rst_ni = 1'b0; #1;
    n_cmp++;
    if ({busy_o, ghr_o, req_ready_o} !== {1'b1, 3'd0, 1'b0}) begin
      n_err++; $display("FAIL midrun_reset busy=%b ghr=%0d rdy=%b want 1 0 0", busy_o, ghr_o, req_ready_o);
    end
    step;
    rst_ni = 1'b1;
    exp_row = 0; cyc = 0;
    while (exp_row < 8 && cyc < 40) begin
      cmd_ready_i = (cyc % 2 == 0); #1;
      n_cmp++;
      if ({cmd_valid_o, cmd_init_o, busy_o, cmd_index_o, cmd_col_mask_o} !== {3'b111, 3'(exp_row), 2'b11}) begin
        n_err++; $display("FAIL stall_walk_c%0d v=%b init=%b busy=%b idx=%0d mask=%b want idx=%0d",
                          cyc, cmd_valid_o, cmd_init_o, busy_o, cmd_index_o, cmd_col_mask_o, exp_row);
      end
      if (cmd_ready_i) exp_row++;
      step;
      cyc++;
    end
    n_cmp++;
    if (exp_row != 8) begin
      n_err++; $display("FAIL stall_walk_timeout rows=%0d want 8", exp_row);
    end
    cmd_ready_i = 1'b1; #1;
    n_cmp++;
    if ({busy_o, cmd_valid_o, ghr_o, req_ready_o} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
      n_err++; $display("FAIL stall_walk_done busy=%b v=%b ghr=%0d rdy=%b want 0 0 0 1", busy_o, cmd_valid_o, ghr_o, req_ready_o);
    end
  endtask

  initial begin
    test_reset;
    test_flush_walk;
    test_single;
    test_fill;
    test_debug;
    test_back_to_back;
    test_flush;
    test_stall_walk;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gbp_upd_sched.md
GBP_UPD_SCHED -- requirements
Module: gbp_upd_sched

Interface
REQ-001 SHALL have parameter NR_ROWS, default 512: predictor rows, power of two, >=4.
REQ-002 SHALL have parameter COLS, default 2: counters per row (INSTR_PER_FETCH).
REQ-003 SHALL have parameter DEPTH, default 4: update queue entries, power of two, >=2.
REQ-004 SHALL derive IDX_W = clog2(NR_ROWS) and COL_W = max(1, clog2(COLS)).
REQ-005 SHALL have port clk_i  in  1  clock.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush_i  in  1  predictor flush request.
REQ-008 SHALL have port debug_mode_i  in  1  core in debug mode.
REQ-009 SHALL have ports req_valid_i/req_ready_o  in/out  1  update request handshake.
REQ-010 SHALL have ports req_index_i (IDX_W), req_col_i (COL_W), req_taken_i (1)  in  resolved branch: row, column, outcome.
REQ-011 SHALL have ports cmd_valid_o/cmd_ready_i  out/in  1  write command handshake to the predictor RAM.
REQ-012 SHALL have ports cmd_index_o (IDX_W), cmd_col_mask_o (COLS), cmd_init_o (1), cmd_taken_o (1)  out  command: row, column one-hot or all-ones, 1 = write reset value {valid=0, ctr=2'b10}, outcome.
REQ-013 SHALL have port ghr_o  out  IDX_W  global history register.
REQ-014 SHALL have port busy_o  out  1  high while flushing.

Function
REQ-015 SHALL implement two states: FLUSH (row walk) and RUN.
REQ-016 FLUSH SHALL drive cmd_valid_o=1, cmd_init_o=1, cmd_index_o=row counter, cmd_col_mask_o=all ones, cmd_taken_o=0; the counter increments on each cmd_ready_i.
REQ-017 FLUSH SHALL transition to RUN the cycle after row NR_ROWS-1 is accepted; total walk NR_ROWS accepted beats.
REQ-018 busy_o SHALL equal (state==FLUSH); req_ready_o SHALL be 0 in FLUSH.
REQ-019 In RUN, req_ready_o SHALL equal !full && !flush_i, with no combinational path from cmd_ready_i.
REQ-020 An accepted request with debug_mode_i=0 SHALL be enqueued and shift ghr_o left by one, inserting req_taken_i at bit 0; with debug_mode_i=1 it SHALL be discarded, with GHR unchanged.
REQ-021 In RUN, cmd_valid_o SHALL equal !empty, with cmd_init_o=0, cmd_col_mask_o=one-hot of the head column, and head index/taken; pop on cmd_ready_i.
REQ-022 Simultaneous push and pop SHALL keep occupancy constant; pointers wrap modulo DEPTH; the queue is strictly FIFO.
REQ-023 flush_i in RUN SHALL clear the queue and GHR and enter FLUSH at row 0 next cycle; any request presented that cycle is not accepted.
REQ-024 flush_i in FLUSH SHALL restart the walk at row 0 next cycle, overriding any increment in that cycle.
REQ-025 cmd fields SHALL hold stable while cmd_valid_o=1 and cmd_ready_i=0, except when flush_i is asserted.

Reset
REQ-026 During reset the block SHALL hold state=FLUSH, row counter 0, queue empty, ghr_o=0, busy_o=1, req_ready_o=0.
REQ-027 After reset deassertion the block SHALL perform a full flush walk before accepting requests.
REQ-028 Reset asserted mid-walk or mid-RUN SHALL discard all progress and queued entries.

Configuration
REQ-029 SHALL support macro GBP_SCHED_BYPASS_EN.
REQ-030 With the macro defined, in RUN with the queue empty, a request (debug_mode_i=0) SHALL appear on cmd_* in the same cycle; if cmd_ready_i=1, it SHALL not be enqueued.
REQ-031 With the macro undefined, a request SHALL appear on cmd_* no earlier than one cycle after acceptance.

Verification
REQ-032 NR_ROWS=8, COLS=2, cmd_ready_i=1: reset release -> cmd_init_o=1 for indices 0..7 on 8 consecutive cycles, busy_o falls, then req_ready_o=1.
REQ-033 Push 5 requests with cmd_ready_i=0, DEPTH=4 -> 4 accepted, then req_ready_o=0; with cmd_ready_i=1, drain in order; ghr_o reflects 4 taken bits only.
REQ-034 Request index=3, col=1, taken=1, ghr=0 -> cmd index 3, mask 2'b10, taken 1; ghr_o=1; latency 0 with GBP_SCHED_BYPASS_EN, 1 without.
REQ-035 debug_mode_i=1 with 3 requests -> all handshakes complete, no cmd_valid_o, ghr_o unchanged.
REQ-036 flush_i with 2 entries queued -> queue empty, ghr_o=0, walk restarts at row 0; flush_i again at row 5 -> next index 0.
REQ-037 cmd_ready_i toggling 1/0 during the walk -> each index issued exactly once, cmd fields stable while stalled.
